// File: rtl/output_layer.sv
// Output fully-connected layer of the digit recognizer: serial MAC of hidden activations
// against 10-wide weight rows, then a hard-sigmoid squash to 4-bit per-digit confidences.
module output_layer #(
    parameter int N_HIDDEN = 16,
    parameter int ACT_W    = 8,
    parameter int WGT_W    = 8,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 10
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        act_valid,
    input  logic [ACT_W-1:0]            act_data,
    input  logic                        act_last,
    output logic                        act_ready,
    output logic [$clog2(N_HIDDEN)-1:0] weight_addr,
    input  logic [0:9][WGT_W-1:0]       weight_data,
    output logic [0:9][3:0]             digit_weights,
    output logic                        network_done,
    output logic                        frame_err
);

    localparam int AW     = $clog2(N_HIDDEN);
    localparam int PROD_W = ACT_W + WGT_W + 1;
    localparam logic [AW-1:0] LAST_BEAT = AW'(N_HIDDEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SQUASH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic [3:0]               j_q, j_d;
    logic                     err_q, err_d;
    logic signed [ACC_W-1:0]  acc_q [10];
    logic signed [ACC_W-1:0]  acc_d [10];
    logic [0:9][3:0]          dw_q, dw_d;
    logic                     accept;
    logic                     at_last_beat;

    // Activation is unsigned, so it is zero-extended before the signed multiply.
    function automatic logic signed [PROD_W-1:0] mul(input logic [ACT_W-1:0] a,
                                                     input logic [WGT_W-1:0] w);
        mul = $signed({1'b0, a}) * $signed(w);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0]  a,
                                                        input logic signed [PROD_W-1:0] p);
        logic signed [ACC_W:0] s;
        s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p});
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    // Hard sigmoid: floor-shift, recentre on 8, clamp into the 4-bit range.
    function automatic logic [3:0] squash(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W:0]   t;
        sh = a >>> SHIFT;
        t  = $signed({sh[ACC_W-1], sh}) + $signed((ACC_W+1)'(8));
        if (t[ACC_W])
            squash = 4'd0;
        else if (t > $signed((ACC_W+1)'(15)))
            squash = 4'd15;
        else
            squash = t[3:0];
    endfunction

    assign act_ready     = (state_q == ACCUM);
    assign accept        = act_valid && act_ready;
    assign at_last_beat  = (cnt_q == LAST_BEAT);
    assign weight_addr   = cnt_q;
    assign digit_weights = dw_q;
    assign network_done  = (state_q == DONE);
    assign frame_err     = (state_q == DONE) && err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        err_d   = err_q;
        acc_d   = acc_q;
        dw_d    = dw_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    for (int k = 0; k < 10; k++)
                        acc_d[k] = sat_add(acc_q[k], mul(act_data, weight_data[k]));
                    cnt_d = cnt_q + AW'(1);
                    // Either end condition closes the frame; disagreement is a framing error.
                    if (act_last || at_last_beat) begin
                        state_d = SQUASH;
                        err_d   = (act_last != at_last_beat);
                        j_d     = 4'd0;
                    end
                end
            end
            SQUASH: begin
                dw_d[j_q] = squash(acc_q[j_q]);
                if (j_q == 4'd9)
                    state_d = DONE;
                else
                    j_d = j_q + 4'd1;
            end
            DONE: begin
                state_d = ACCUM;
                cnt_d   = '0;
                j_d     = 4'd0;
                err_d   = 1'b0;
                for (int k = 0; k < 10; k++)
                    acc_d[k] = '0;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            j_q     <= 4'd0;
            err_q   <= 1'b0;
            dw_q    <= '0;
            for (int k = 0; k < 10; k++)
                acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            err_q   <= err_d;
            dw_q    <= dw_d;
            for (int k = 0; k < 10; k++)
                acc_q[k] <= acc_d[k];
        end
    end

endmodule
